counter_window_ctrl: RTL and testbench
======================================

Name: counter_window_ctrl

Overview:
- Sequencing controller for an external ripple up-counter: clears it, gates its count enable for a programmable window, then waits a fixed settle time for the ripple to resolve.
- Captures the settled count plus an overflow flag and presents them on a valid/ready result interface.
- Sits between the counter datapath and the host/measurement logic.

Parameters:
CNT_W, 4, width of the controlled counter value
WIN_W, 8, width of the window-length operand
SETTLE_CYC, 3, clk cycles waited after cnt_en drops before sampling cnt_q (must be >= 1)

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-high; clock name clk, reset name rst
start  in  1  request one measurement; sampled only in IDLE
abort  in  1  cancel the current measurement from any state
win_len  in  WIN_W  number of cycles cnt_en is held high; latched on accepted start
cnt_clr  out  1  synchronous clear strobe to the counter
cnt_en  out  1  count gate to the counter
cnt_q  in  CNT_W  counter value
busy  out  1  high in every state except IDLE
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  CNT_W  captured count
res_ovf  out  1  counter wrapped during the window

Behaviour:
- Reset: state IDLE; cnt_clr, cnt_en, busy, res_valid, res_ovf all 0; res_data 0; internal window/settle counters and prev-sample register 0.
- All outputs are decoded from registered state/counters only (Moore); no input-to-output combinational path.
- IDLE: start=1 latches win_len, clears ovf and prev-sample, next state CLEAR.
- CLEAR: exactly 1 cycle with cnt_clr=1. Next state is COUNT if latched length != 0; otherwise SETTLE.
- COUNT: cnt_en=1 for exactly win_len cycles, using a down-counter loaded on accept. SETTLE follows after the last cycle.
- SETTLE: cnt_en=0 for SETTLE_CYC cycles. On the final edge, cnt_q is captured into res_data and ovf into res_ovf; next state HOLD.
- HOLD: res_valid=1; res_data and res_ovf are stable. res_ready=1 leads to IDLE, with res_valid low the next cycle. start is ignored in HOLD.
- Latency: start in cycle 0 gives cnt_clr in cycle 1, cnt_en in cycles 2..win_len+1, and res_valid first in cycle win_len+SETTLE_CYC+2. With win_len=0, res_valid is first in cycle SETTLE_CYC+2 and cnt_en never rises.
- Overflow detection:
  - During COUNT and SETTLE, register cnt_q each cycle into prev.
  - If cnt_q < prev, set sticky ovf.
  - Flagged regardless of the number of wraps.
- Abort:
  - abort=1 in any state leads to IDLE on the next edge, with cnt_en/cnt_clr low from that edge.
  - Abort discards the result: res_valid drops and no handshake occurs.
  - abort overrides start in IDLE and res_ready in HOLD.
- Async rst mid-operation: immediate return to reset values, independent of clk.
- busy=1 from CLEAR through HOLD inclusive.
- Second start while busy: ignored, not queued.

Decomposition:
- Shared package cwc_pkg holds:
  - state enum IDLE/CLEAR/COUNT/SETTLE/HOLD (3-bit binary encoding);
  - the CLR_CYC=1 constant;
  - a helper function for the settle-counter width, $clog2(SETTLE_CYC+1).
- One sub-module, cwc_down_timer: a loadable down-counter with a zero flag. It is instantiated twice, once for the window and once for the settle wait.

Test Plan:
1. Reset check: assert rst asynchronously mid-cycle -> all outputs 0 immediately; deassert -> IDLE, busy=0.
2. Nominal window: bench counter model increments each cnt_en cycle; start with win_len=5, SETTLE_CYC=3 -> cnt_clr in cycle 1, cnt_en in cycles 2-6, res_valid in cycle 10, res_data=5, res_ovf=0. res_ready held low 4 cycles -> data stable; res_ready=1 -> IDLE.
3. Overflow: win_len=20 with CNT_W=4 -> res_data=4, res_ovf=1.
4. Zero window: win_len=0 -> cnt_en never high, res_valid in cycle 5, res_data=0, res_ovf=0.
5. Abort: abort during COUNT cycle 3 of win_len=10 -> cnt_en low next cycle, IDLE, res_valid never asserted. abort+res_ready together in HOLD -> IDLE, no result.
6. Ignored starts: start pulses during COUNT and HOLD -> no restart, win_len change not latched, exactly one result produced.

Source files
------------

// File: rtl/cwc_pkg.sv
// Shared definitions for the counter window controller.
//   state_t      : controller FSM states (3-bit binary encoding)
//   CLR_CYC      : length of the counter clear strobe in cycles
//   cwc_settle_w : width of the settle timer for a given settle length
package cwc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        COUNT  = 3'd2,
        SETTLE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam int unsigned CLR_CYC = 1;

    function automatic int cwc_settle_w(input int cyc);
        return $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/cwc_down_timer.sv
// Loadable down-counter with a zero flag.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; holds at zero
//   zero      : counter value is zero
module cwc_down_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/counter_window_ctrl.sv
// Sequencing controller for an external ripple up-counter: clears it, gates
// its enable for win_len cycles, waits SETTLE_CYC cycles, then captures the
// count and a wrap flag onto a valid/ready result interface.
//   clk, rst            : clock, asynchronous active-high reset
//   start, abort        : begin a measurement (IDLE only) / cancel from any state
//   win_len             : window length, latched on accepted start
//   cnt_clr, cnt_en     : clear strobe and count gate to the counter
//   cnt_q               : counter value
//   busy                : high in every state except IDLE
//   res_valid/res_ready : result handshake
//   res_data, res_ovf   : captured count and wrap flag
module counter_window_ctrl
    import cwc_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int WIN_W      = 8,
    parameter int SETTLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_data,
    output logic             res_ovf
);

    localparam int SW = cwc_settle_w(SETTLE_CYC);

    state_t           state, state_n;
    logic             accept;
    logic             win_zero, settle_zero, settle_load;
    logic [CNT_W-1:0] prev;
    logic             ovf;

    assign accept = (state == IDLE) && start && !abort;

    // Window timer is loaded on accept and also decremented during CLEAR, so
    // COUNT sees win_len-1 .. 0 and its last cycle is the one where zero is set.
    cwc_down_timer #(.W(WIN_W)) u_win (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (win_len),
        .dec      ((state == CLEAR) || (state == COUNT)),
        .zero     (win_zero)
    );

    // Settle timer is loaded with SETTLE_CYC-1 on entry, so SETTLE lasts
    // SETTLE_CYC cycles and ends on the cycle where zero is set.
    assign settle_load = (state_n == SETTLE) && (state != SETTLE);

    cwc_down_timer #(.W(SW)) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .load_val (SW'(SETTLE_CYC - 1)),
        .dec      (state == SETTLE),
        .zero     (settle_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (state)
            IDLE:   busy      = 1'b0;
            CLEAR:  cnt_clr   = 1'b1;
            COUNT:  cnt_en    = 1'b1;
            HOLD:   res_valid = 1'b1;
            default: ;
        endcase
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_n = CLEAR;
                CLEAR:   state_n = win_zero ? SETTLE : COUNT;
                COUNT:   if (win_zero) state_n = SETTLE;
                SETTLE:  if (settle_zero) state_n = HOLD;
                HOLD:    if (res_ready) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= '0;
            ovf      <= 1'b0;
            res_data <= '0;
            res_ovf  <= 1'b0;
        end else begin
            if (accept) begin
                prev <= '0;
                ovf  <= 1'b0;
            end else if ((state == COUNT) || (state == SETTLE)) begin
                prev <= cnt_q;
                if (cnt_q < prev) begin
                    ovf <= 1'b1;
                end
            end
            // A wrap seen on the capture edge itself is folded into the result.
            if ((state == SETTLE) && (state_n == HOLD)) begin
                res_data <= cnt_q;
                res_ovf  <= ovf | (cnt_q < prev);
            end
        end
    end

endmodule

// File: tb/tb_counter_window_ctrl.sv
module tb_counter_window_ctrl;

    localparam int CNT_W      = 4;
    localparam int WIN_W      = 8;
    localparam int SETTLE_CYC = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             cnt_clr, cnt_en;
    logic [CNT_W-1:0] cnt_q = '0;
    logic             busy, res_valid;
    logic             res_ready = 1'b0;
    logic [CNT_W-1:0] res_data;
    logic             res_ovf;

    int n_checks = 0;
    int n_errors = 0;

    counter_window_ctrl #(
        .CNT_W      (CNT_W),
        .WIN_W      (WIN_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .win_len   (win_len),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .cnt_q     (cnt_q),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    // External counter model: synchronous clear, count when gated.
    always @(posedge clk) begin
        if (cnt_clr)     cnt_q <= '0;
        else if (cnt_en) cnt_q <= cnt_q + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full measurement: start in cycle 0, follow the window, check latency,
    // gate pattern and result, keep res_ready low hold_cyc cycles, then accept.
    task automatic run_meas(input int len, input int exp_d, input int exp_o,
                            input int hold_cyc, input string nm);
        int cyc, en_n, clr_n, first_en;
        win_len = WIN_W'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1; en_n = 0; clr_n = 0; first_en = 0;
        check({nm, "_clr_c1"}, cnt_clr, 1);
        check({nm, "_busy_c1"}, busy, 1);
        while (!res_valid && cyc < 200) begin
            if (cnt_en) begin
                en_n++;
                if (first_en == 0) first_en = cyc;
            end
            if (cnt_clr) clr_n++;
            tick();
            cyc++;
        end
        check({nm, "_latency"}, cyc, len + SETTLE_CYC + 2);
        check({nm, "_en_cycles"}, en_n, len);
        check({nm, "_clr_cycles"}, clr_n, 1);
        if (len > 0) check({nm, "_first_en"}, first_en, 2);
        check({nm, "_data"}, res_data, exp_d);
        check({nm, "_ovf"}, res_ovf, exp_o);
        for (int i = 0; i < hold_cyc; i++) begin
            tick();
            check({nm, "_hold_valid"}, res_valid, 1);
            check({nm, "_hold_data"}, res_data, exp_d);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({nm, "_valid_after_ack"}, res_valid, 0);
        check({nm, "_busy_after_ack"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, cyc;

        // Reset state
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_en", cnt_en, 0);
        check("rst_clr", cnt_clr, 0);
        check("rst_data", res_data, 0);
        check("rst_ovf", res_ovf, 0);
        rst = 1'b0;
        tick();
        check("rst_idle_busy", busy, 0);

        // Nominal window with delayed consumer
        run_meas(5, 5, 0, 4, "nom");

        // Asynchronous reset in the middle of COUNT, away from a clock edge
        win_len = 8'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("mid_en_before", cnt_en, 1);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_en", cnt_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_clr", cnt_clr, 0);
        check("mid_rst_data", res_data, 0);
        check("mid_rst_valid", res_valid, 0);
        #2 rst = 1'b0;
        tick();
        check("mid_rst_idle", busy, 0);

        // Wrapping window: 20 mod 16
        run_meas(20, 4, 1, 0, "ovf");

        // Zero-length window
        run_meas(0, 0, 0, 0, "zero");

        // Abort during the third COUNT cycle
        win_len = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("abort_en_before", cnt_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_en_after", cnt_en, 0);
        check("abort_busy", busy, 0);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid || busy) nv++;
        end
        check("abort_no_result", nv, 0);

        // Abort together with res_ready in HOLD
        win_len = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("habort_reach_hold", res_valid, 1);
        abort = 1'b1;
        res_ready = 1'b1;
        tick();
        abort = 1'b0;
        res_ready = 1'b0;
        check("habort_valid", res_valid, 0);
        check("habort_busy", busy, 0);

        // Starts while busy are ignored
        win_len = 8'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        win_len = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 4;
        while (!res_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("ign_latency", cyc, 6 + SETTLE_CYC + 2);
        check("ign_data", res_data, 6);
        win_len = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_hold_valid", res_valid, 1);
        check("ign_hold_data", res_data, 6);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("ign_ack_valid", res_valid, 0);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) nv++;
        end
        check("ign_not_queued", nv, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
